// File: rtl/sub_segment.sv
// Combinational W-bit subtract slice: d = a - b - bin, with borrow-out.
// Chained across pipeline stages by the top level.
module sub_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] diffWide;

    // The extra top bit of the widened difference goes to 1 exactly when a < b + bin.
    assign diffWide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d        = diffWide[W-1:0];
    assign bout     = diffWide[W];

endmodule

// File: rtl/pipelined_subtractor.sv
// Borrow-segmented pipelined subtractor: one W-bit slice per stage, operands skewed
// forward and lower result slices deskewed so a whole transaction emerges at once.
module pipelined_subtractor #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         stall,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         Ovf,
    output logic         out_valid
);

    localparam int W = N / STAGES;

    logic [N-1:0] diff_q;
    logic         bout_q;
    logic         ovf_q;
    logic         outValid_q;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int LO = k * W;
        localparam int AW = N - LO;

        logic [AW-1:0]     aIn;
        logic [AW-1:0]     bIn;
        logic              borrowIn;
        logic              validIn;
        logic [W-1:0]      dSeg;
        logic              borrowSeg;
        logic [LO+W-1:0]   res_d;

        // Stage 0 sees the raw inputs; later stages see only the still-unconsumed upper bits.
        if (k == 0) begin : gHead
            assign aIn      = A;
            assign bIn      = B;
            assign borrowIn = Bin;
            assign validIn  = in_valid;
            assign res_d    = dSeg;
        end else begin : gTail
            assign aIn      = gStage[k-1].gMid.opA_q;
            assign bIn      = gStage[k-1].gMid.opB_q;
            assign borrowIn = gStage[k-1].gMid.borrow_q;
            assign validIn  = gStage[k-1].gMid.valid_q;
            assign res_d    = {dSeg, gStage[k-1].gMid.res_q};
        end

        sub_segment #(.W(W)) uSeg (
            .a    (aIn[W-1:0]),
            .b    (bIn[W-1:0]),
            .bin  (borrowIn),
            .d    (dSeg),
            .bout (borrowSeg)
        );

        if (k < STAGES - 1) begin : gMid
            logic [AW-W-1:0] opA_q;
            logic [AW-W-1:0] opB_q;
            logic [LO+W-1:0] res_q;
            logic            borrow_q;
            logic            valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    opA_q    <= '0;
                    opB_q    <= '0;
                    res_q    <= '0;
                    borrow_q <= 1'b0;
                    valid_q  <= 1'b0;
                end else if (!stall) begin
                    opA_q    <= aIn[AW-1:W];
                    opB_q    <= bIn[AW-1:W];
                    res_q    <= res_d;
                    borrow_q <= borrowSeg;
                    valid_q  <= validIn;
                end
            end
        end else begin : gLast
            // Result registers only load on a valid transaction so bubbles leave them untouched.
            always_ff @(posedge clk) begin
                if (reset) begin
                    diff_q     <= '0;
                    bout_q     <= 1'b0;
                    ovf_q      <= 1'b0;
                    outValid_q <= 1'b0;
                end else if (!stall) begin
                    outValid_q <= validIn;
                    if (validIn) begin
                        diff_q <= res_d;
                        bout_q <= borrowSeg;
                        ovf_q  <= (aIn[AW-1] != bIn[AW-1]) && (dSeg[W-1] != aIn[AW-1]);
                    end
                end
            end
        end
    end

    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Ovf       = ovf_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed self-checking bench for pipelined_subtractor at N=8, STAGES=2.
// Expected values are hand-computed constants.
module tb_pipelined_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       stall;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic [7:0] Diff;
    logic       Bout;
    logic       Ovf;
    logic       out_valid;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] vecA   [8] = '{8'h10, 8'h00, 8'h80, 8'h05, 8'h7F, 8'h00, 8'hFF, 8'h20};
    logic [7:0] vecB   [8] = '{8'h01, 8'h01, 8'h01, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h0F};
    logic       vecBin [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] vecD   [8] = '{8'h0F, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h10};
    logic       vecBo  [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    logic       vecOv  [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

    logic [7:0] bbA   [4] = '{8'h50, 8'h10, 8'h00, 8'h80};
    logic [7:0] bbB   [4] = '{8'h20, 8'h01, 8'h01, 8'h01};
    logic [7:0] bbD   [4] = '{8'h30, 8'h0F, 8'hFF, 8'h7F};
    logic       bbBo  [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
    logic       bbOv  [4] = '{1'b0,  1'b0,  1'b0,  1'b1};

    always #5 clk = ~clk;

    pipelined_subtractor #(.N(8), .STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .stall     (stall),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .out_valid (out_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
        in_valid = v;
        A        = a;
        B        = b;
        Bin      = bi;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        applyStimulus(1'b1, 8'h50, 8'h20, 1'b0);
        step();
        step();
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== 11'h000) begin
            failCount++;
            $display("[TB] FAIL reset_hold: got {v,bo,ov,d}=%h expected 000", {out_valid, Bout, Ovf, Diff});
        end
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            assertCount++;
            if ({out_valid, Bout, Ovf, Diff} !== 11'h000) begin
                failCount++;
                $display("[TB] FAIL post_reset_idle[%0d]: got %h expected 000", i, {out_valid, Bout, Ovf, Diff});
            end
        end
    endtask

    task automatic test_basic();
        applyStimulus(1'b1, 8'h50, 8'h20, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== 11'h000) begin
            failCount++;
            $display("[TB] FAIL basic_latency: got %h expected 000", {out_valid, Bout, Ovf, Diff});
        end
        step();
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== {1'b1, 1'b0, 1'b0, 8'h30}) begin
            failCount++;
            $display("[TB] FAIL basic_result: got %h expected %h", {out_valid, Bout, Ovf, Diff}, {1'b1, 1'b0, 1'b0, 8'h30});
        end
        step();
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== {1'b0, 1'b0, 1'b0, 8'h30}) begin
            failCount++;
            $display("[TB] FAIL basic_pulse_end: got %h expected %h", {out_valid, Bout, Ovf, Diff}, {1'b0, 1'b0, 1'b0, 8'h30});
        end
    endtask

    task automatic test_borrow_overflow();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecA[i], vecB[i], vecBin[i]);
            step();
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            step();
            assertCount++;
            if ({out_valid, Bout, Ovf, Diff} !== {1'b1, vecBo[i], vecOv[i], vecD[i]}) begin
                failCount++;
                $display("[TB] FAIL vector[%0d] %h-%h-%b: got %h expected %h", i, vecA[i], vecB[i], vecBin[i],
                         {out_valid, Bout, Ovf, Diff}, {1'b1, vecBo[i], vecOv[i], vecD[i]});
            end
            step();
            assertCount++;
            if ({out_valid, Bout, Ovf, Diff} !== {1'b0, vecBo[i], vecOv[i], vecD[i]}) begin
                failCount++;
                $display("[TB] FAIL vector_hold[%0d]: got %h expected %h", i,
                         {out_valid, Bout, Ovf, Diff}, {1'b0, vecBo[i], vecOv[i], vecD[i]});
            end
        end
    endtask

    task automatic test_back_to_back();
        int          got;
        int          sel;
        logic        isStall;
        logic [10:0] snap;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            isStall = (c >= 2 && c <= 4);
            sel = (c == 0) ? 0 : (c == 1) ? 1 : (c == 5) ? 2 : (c == 6) ? 3 : -1;
            stall = isStall;
            if (sel >= 0)
                applyStimulus(1'b1, bbA[sel], bbB[sel], 1'b0);
            else if (isStall)
                applyStimulus(1'b1, 8'hAA, 8'h11, 1'b1);
            else
                applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            snap = {out_valid, Bout, Ovf, Diff};
            step();
            if (isStall) begin
                assertCount++;
                if ({out_valid, Bout, Ovf, Diff} !== snap) begin
                    failCount++;
                    $display("[TB] FAIL stall_freeze[c=%0d]: got %h expected %h", c, {out_valid, Bout, Ovf, Diff}, snap);
                end
            end else if (out_valid === 1'b1) begin
                assertCount++;
                if (got >= 4) begin
                    failCount++;
                    $display("[TB] FAIL b2b_extra[c=%0d]: got result %h expected none", c, Diff);
                end else if ({Bout, Ovf, Diff} !== {bbBo[got], bbOv[got], bbD[got]}) begin
                    failCount++;
                    $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", got, {Bout, Ovf, Diff},
                             {bbBo[got], bbOv[got], bbD[got]});
                end
                got++;
            end
        end
        stall = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        assertCount++;
        if (got != 4) begin
            failCount++;
            $display("[TB] FAIL b2b_count: got %0d results expected 4", got);
        end
    endtask

    task automatic test_reset_flush();
        applyStimulus(1'b1, 8'h50, 8'h20, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        stall = 1'b1;
        step();
        stall = 1'b0;
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== 11'h000) begin
            failCount++;
            $display("[TB] FAIL flush_clear: got %h expected 000", {out_valid, Bout, Ovf, Diff});
        end
        reset = 1'b0;
        applyStimulus(1'b1, 8'h10, 8'h01, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== 11'h000) begin
            failCount++;
            $display("[TB] FAIL flush_no_ghost: got %h expected 000", {out_valid, Bout, Ovf, Diff});
        end
        step();
        assertCount++;
        if ({out_valid, Bout, Ovf, Diff} !== {1'b1, 1'b0, 1'b0, 8'h0F}) begin
            failCount++;
            $display("[TB] FAIL first_after_reset: got %h expected %h", {out_valid, Bout, Ovf, Diff}, {1'b1, 1'b0, 1'b0, 8'h0F});
        end
        step();
        assertCount++;
        if (out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL flush_tail: got out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        Bin      = 1'b0;
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_back_to_back();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
